// File: rtl/mem_line_writer.sv
// Serialises fixed-width words into lowercase ASCII hex text lines, MSB nibble first,
// fields separated by ' ' and lines terminated by '\n', over a valid/ready character stream.
module mem_line_writer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned WORDS_PER_LINE = 2,
    parameter int unsigned LINE_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      flush,
    output logic                      char_valid,
    input  logic                      char_ready,
    output logic [7:0]                char_data,
    output logic [LINE_CNT_WIDTH-1:0] lines_written,
    output logic                      busy
);

    localparam int unsigned NIB  = (DATA_WIDTH + 3) / 4;
    localparam int unsigned NW   = NIB * 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned FCW  = $clog2(WORDS_PER_LINE + 1);

    typedef enum logic [1:0] {StIdle, StHex, StSep, StNl} state_e;

    state_e                    state_q, state_d;
    logic [NW-1:0]             data_q, data_d;
    logic [IDXW-1:0]           nib_idx_q, nib_idx_d;
    logic [FCW-1:0]            field_cnt_q, field_cnt_d;
    logic                      flush_pending_q, flush_pending_d;
    logic [LINE_CNT_WIDTH-1:0] lines_q, lines_d;

    logic       hs;
    logic [3:0] nib;

    assign in_ready      = (state_q == StIdle);
    assign char_valid    = (state_q != StIdle);
    assign busy          = (state_q != StIdle) || flush_pending_q;
    assign lines_written = lines_q;
    assign hs            = char_valid && char_ready;

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < int'(NIB); i++) begin
            if (nib_idx_q == IDXW'(i)) nib = data_q[4*i +: 4];
        end
    end

    always_comb begin
        char_data = 8'h00;
        unique case (state_q)
            StIdle: char_data = 8'h00;
            StHex:  char_data = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
            StSep:  char_data = 8'h20;
            StNl:   char_data = 8'h0A;
            default: char_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        nib_idx_d       = nib_idx_q;
        field_cnt_d     = field_cnt_q;
        flush_pending_d = flush_pending_q;
        lines_d         = lines_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d    = NW'(in_data);
                    nib_idx_d = IDXW'(NIB - 1);
                    state_d   = StHex;
                    if (flush) flush_pending_d = 1'b1;
                end else if ((flush || flush_pending_q) && (field_cnt_q != '0)) begin
                    state_d = StNl;
                end
            end
            StHex: begin
                if (flush) flush_pending_d = 1'b1;
                if (hs) begin
                    if (nib_idx_q != '0) begin
                        nib_idx_d = nib_idx_q - IDXW'(1);
                    end else begin
                        field_cnt_d = field_cnt_q + FCW'(1);
                        // A pending flush ends the line here instead of emitting a separator.
                        if ((32'(field_cnt_q) + 32'd1 == WORDS_PER_LINE) || flush_pending_q
                            || flush) begin
                            state_d = StNl;
                        end else begin
                            state_d = StSep;
                        end
                    end
                end
            end
            StSep: begin
                if (flush) flush_pending_d = 1'b1;
                if (hs) state_d = StIdle;
            end
            StNl: begin
                if (hs) begin
                    lines_d         = lines_q + LINE_CNT_WIDTH'(1);
                    field_cnt_d     = '0;
                    flush_pending_d = 1'b0;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            data_q          <= '0;
            nib_idx_q       <= '0;
            field_cnt_q     <= '0;
            flush_pending_q <= 1'b0;
            lines_q         <= '0;
        end else begin
            state_q         <= state_d;
            data_q          <= data_d;
            nib_idx_q       <= nib_idx_d;
            field_cnt_q     <= field_cnt_d;
            flush_pending_q <= flush_pending_d;
            lines_q         <= lines_d;
        end
    end

endmodule

// File: tb/tb_mem_line_writer.sv
// Directed bench for mem_line_writer: a 16-bit/2-field instance and a 10-bit/1-field instance
// share stimulus; sel chooses which one is driven and observed.
module tb_mem_line_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        char_ready = 1'b1;
    logic        sel = 1'b0;
    logic [15:0] in_data = 16'h0;

    logic        rdy16, cv16, busy16, rdy10, cv10, busy10;
    logic [7:0]  cd16, cd10;
    logic [15:0] lw16, lw10;

    logic        rdy, cv, busy;
    logic [7:0]  cd;
    logic [15:0] lw;

    int checks = 0;
    int errors = 0;
    int rmode  = 0;
    int rk     = 0;
    logic [7:0] got[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always #5 clk = ~clk;

    mem_line_writer #(.DATA_WIDTH(16), .WORDS_PER_LINE(2), .LINE_CNT_WIDTH(16)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_ready(rdy16), .in_data(in_data),
        .flush(flush && !sel),
        .char_valid(cv16), .char_ready(char_ready), .char_data(cd16),
        .lines_written(lw16), .busy(busy16)
    );

    mem_line_writer #(.DATA_WIDTH(10), .WORDS_PER_LINE(1), .LINE_CNT_WIDTH(16)) u10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_ready(rdy10), .in_data(in_data[9:0]),
        .flush(flush && sel),
        .char_valid(cv10), .char_ready(char_ready), .char_data(cd10),
        .lines_written(lw10), .busy(busy10)
    );

    assign rdy  = sel ? rdy10  : rdy16;
    assign cv   = sel ? cv10   : cv16;
    assign busy = sel ? busy10 : busy16;
    assign cd   = sel ? cd10   : cd16;
    assign lw   = sel ? lw10   : lw16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // char_ready pattern: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready
    always begin
        @(posedge clk);
        #1;
        case (rmode)
            0: char_ready = 1'b1;
            1: begin
                char_ready = ((rk % 4) == 0) || ((rk % 4) == 3);
                rk++;
            end
            default: char_ready = 1'b0;
        endcase
    end

    // Capture handshaken characters and check stall stability and in_ready exclusion.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(cv), 32'd1);
                chk("stall_data", 32'(cd), 32'(stall_data));
            end
            if (cv) chk("in_ready_low", 32'(rdy), 32'd0);
            if (cv && char_ready) got.push_back(cd);
            stall_prev = cv && !char_ready;
            stall_data = cd;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 500), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || cv) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 500), 32'd1);
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic check_str(input string tag, input string exp);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < got.size(); i++) begin
            chk(tag, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 32'(rdy), 32'd1);
        chk("rst_char_valid", 32'(cv), 32'd0);
        chk("rst_char_data", 32'(cd), 32'h00);
        chk("rst_lines", 32'(lw), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: basic two-field line, first char one cycle after accept
        send(16'h12ab);
        @(negedge clk);
        chk("t1_latency_valid", 32'(cv), 32'd1);
        chk("t1_first_char", 32'(cd), 32'h31);
        send(16'h0003);
        wait_idle();
        check_str("t1_chars", "12ab 0003\n");
        chk("t1_lines", 32'(lw), 32'd1);

        // 2: same words under 1,0,0,1 backpressure
        do_reset();
        rk = 0;
        rmode = 1;
        send(16'h12ab);
        send(16'h0003);
        wait_idle();
        rmode = 0;
        check_str("t2_chars", "12ab 0003\n");
        chk("t2_lines", 32'(lw), 32'd1);

        // 3: flush in IDLE with a partial line
        do_reset();
        send(16'hffff);
        wait_idle();
        chk("t3_lines_before", 32'(lw), 32'd0);
        repeat (3) @(posedge clk);
        pulse_flush();
        wait_idle();
        check_str("t3_chars", "ffff \n");
        chk("t3_lines", 32'(lw), 32'd1);

        // 4: flush during a stalled first nibble, then a flush with an empty line
        do_reset();
        rmode = 2;
        char_ready = 1'b0;
        send(16'h0a0b);
        chk("t4_stalled_valid", 32'(cv), 32'd1);
        pulse_flush();
        rmode = 0;
        wait_idle();
        check_str("t4_chars", "0a0b\n");
        chk("t4_lines", 32'(lw), 32'd1);
        got.delete();
        pulse_flush();
        repeat (5) @(negedge clk);
        chk("t4_empty_flush_chars", 32'(got.size()), 32'd0);
        chk("t4_empty_flush_valid", 32'(cv), 32'd0);
        chk("t4_empty_flush_lines", 32'(lw), 32'd1);

        // 6: asynchronous reset mid-line (lines_written is 1 here)
        got.delete();
        send(16'h1234);
        begin
            int n = 0;
            while (got.size() < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t6_wait_timeout", 32'(n < 100), 32'd1);
        end
        check_str("t6_partial", "12");
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(cv), 32'd0);
        chk("t6_rst_lines", 32'(lw), 32'd0);
        chk("t6_rst_ready", 32'(rdy), 32'd1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        send(16'h5678);
        wait_idle();
        check_str("t6_chars", "5678 ");
        chk("t6_lines", 32'(lw), 32'd0);

        // 5: 10-bit words, one field per line
        sel = 1'b1;
        got.delete();
        send(16'h03ff);
        send(16'h0001);
        wait_idle();
        check_str("t5_chars", "3ff\n001\n");
        chk("t5_lines", 32'(lw), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
